port_b_reader: RTL

- Read-side counterpart of the PORTB direction fan-out block: gathers the eight RB pins back into the core.
- Synchronizes the pins to clk and forms the PORTB read value, selecting pin or output latch per TRIS bit.
- Generates the RB0/INT edge flag (INTF) and the RB7:RB4 interrupt-on-change flag (RBIF).
- Sits between the pad pins and the file-register read mux / interrupt logic of the PIC16F84 model.

---
 rtl/pic16_port_pkg.sv | 22 ++
 rtl/port_b_reader_pin_sync.sv | 36 +++
 rtl/port_b_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pic16_port_pkg.sv
//------------------------------------------------------------------------------
// pic16_port_pkg
//   Shared definitions for the PIC16F84 PORTB model: port width, the lowest
//   interrupt-on-change bit and the reader's warm-up state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pic16_port_pkg;

  localparam int PORTB_W  = 8;
  // RB7:RB4 are the change-monitored pins
  localparam int RBIOC_LO = 4;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } warm_state_t;

endpackage

`default_nettype wire

// File: rtl/port_b_reader_pin_sync.sv
//------------------------------------------------------------------------------
// pin_sync
//   SYNC_STAGES-deep single-bit synchronizer for one asynchronous pad level.
//   Ports:
//     clk  - core clock
//     rst  - synchronous active-high reset, clears every stage
//     din  - raw asynchronous pin level
//     dout - synchronized level (last stage of the chain)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/port_b_reader.sv
//------------------------------------------------------------------------------
// port_b_reader
//   Read side of PORTB: synchronizes RB7..RB0, forms the PORTB read value
//   (pin when TRIS bit = 1, output latch when 0) and generates the RB0/INT
//   edge flag (intf) and the RB7:RB4 port-change flag (rbif).
//   Ports:
//     clk, rst        - core clock, synchronous active-high reset
//     rb0..rb7        - raw asynchronous pad levels
//     tris_val[7:0]   - TRISB (1 = input)
//     out_latch[7:0]  - PORTB output data latch
//     intedg          - 1 = rising RB0 edge, 0 = falling
//     rd_strobe       - core read of PORTB, re-arms the change snapshot
//     clr_rbif        - firmware clear of rbif
//     clr_intf        - firmware clear of intf
//     port_val[7:0]   - PORTB read data (combinational)
//     rbif, intf      - level flags
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module port_b_reader
  import pic16_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rb0,
  input  logic               rb1,
  input  logic               rb2,
  input  logic               rb3,
  input  logic               rb4,
  input  logic               rb5,
  input  logic               rb6,
  input  logic               rb7,
  input  logic [PORTB_W-1:0] tris_val,
  input  logic [PORTB_W-1:0] out_latch,
  input  logic               intedg,
  input  logic               rd_strobe,
  input  logic               clr_rbif,
  input  logic               clr_intf,
  output logic [PORTB_W-1:0] port_val,
  output logic               rbif,
  output logic               intf
);

  localparam int         IOC_W    = PORTB_W - RBIOC_LO;
  localparam logic [1:0] CNT_LAST = 2'(SYNC_STAGES - 1);

  logic [PORTB_W-1:0] pins;
  logic [PORTB_W-1:0] syn;

  assign pins = {rb7, rb6, rb5, rb4, rb3, rb2, rb1, rb0};

  generate
    for (genvar i = 0; i < PORTB_W; i++) begin : g_sync
      pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pins[i]),
        .dout (syn[i])
      );
    end
  endgenerate

  assign port_val = (syn & tris_val) | (out_latch & ~tris_val);

  // Warm-up FSM
  warm_state_t state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WARM;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt keeps its final warm-up value for the first RUN cycle. The
  // synchronizers only carry settled pin data one edge after the count
  // completes, so that cycle still re-arms snap/prev0 with flags held,
  // otherwise pins that were high through reset would raise a false flag.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WARM: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == CNT_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = cnt;
        end
      end
      RUN: begin
        cnt_nxt = 2'd0;
      end
      default: begin
        state_nxt = WARM;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  assign hold = (state == WARM) || (cnt != 2'd0);

  // Change and edge detection
  logic [IOC_W-1:0] snap;
  logic             prev0;
  logic             mis;
  logic             int_edge;

  assign mis      = |((snap ^ syn[PORTB_W-1:RBIOC_LO]) & tris_val[PORTB_W-1:RBIOC_LO]);
  assign int_edge = intedg ? (syn[0] & ~prev0) : (~syn[0] & prev0);

  always_ff @(posedge clk) begin
    if (rst) begin
      snap  <= '0;
      prev0 <= 1'b0;
      rbif  <= 1'b0;
      intf  <= 1'b0;
    end else if (hold) begin
      snap  <= syn[PORTB_W-1:RBIOC_LO];
      prev0 <= syn[0];
      rbif  <= 1'b0;
      intf  <= 1'b0;
    end else begin
      if (rd_strobe) begin
        snap <= syn[PORTB_W-1:RBIOC_LO];
      end
      prev0 <= syn[0];
      // set wins over clear
      rbif  <= mis | (rbif & ~clr_rbif);
      intf  <= int_edge | (intf & ~clr_intf);
    end
  end

endmodule

`default_nettype wire
